// File: rtl/dmem_write_buffer.sv
// Posted-write FIFO between the core data-memory port and the data RAM, with
// store-to-load forwarding. Optional in-place store merging: DMEM_WB_COALESCE_EN.
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [31:0]      data_mem_addr,
  input  logic [31:0]      data_mem_wr_data,
  input  logic             data_mem_wr_ena,
  input  logic             data_mem_rd_ena,
  output logic [31:0]      data_mem_rd_data,
  output logic             data_mem_stall,
  output logic             bk_wr_valid,
  input  logic             bk_wr_ready,
  output logic [31:0]      bk_wr_addr,
  output logic [31:0]      bk_wr_data,
  output logic [31:0]      bk_rd_addr,
  input  logic [31:0]      bk_rd_data,
  output logic [CNT_W-1:0] buffer_count,
  output logic [31:0]      writes_retired
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      retired_q, retired_d;

  logic             full, empty, wr_req, push, pop, coal;
  logic             rd_hit;
  logic [31:0]      rd_word;
  logic [PTR_W-1:0] idx;
  logic             unused_addr_lsb;

`ifdef DMEM_WB_COALESCE_EN
  logic             coal_hit;
  logic [PTR_W-1:0] coal_idx;
`endif

  assign unused_addr_lsb = ^data_mem_addr[1:0];

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_req = data_mem_wr_ena & ena;

  // Walk from oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    rd_hit  = 1'b0;
    rd_word = '0;
    idx     = '0;
`ifdef DMEM_WB_COALESCE_EN
    coal_hit = 1'b0;
    coal_idx = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[idx] == data_mem_addr[31:2])) begin
        rd_hit  = 1'b1;
        rd_word = data_q[idx];
`ifdef DMEM_WB_COALESCE_EN
        // The head is excluded so data under an open handshake never changes.
        if (k != 0) begin
          coal_hit = 1'b1;
          coal_idx = idx;
        end
`endif
      end
    end
  end

`ifdef DMEM_WB_COALESCE_EN
  assign coal = wr_req & coal_hit;
`else
  assign coal = 1'b0;
`endif

  assign push = wr_req & ~full & ~coal;
  assign pop  = ~empty & bk_wr_ready;

  always_comb begin
    head_d    = head_q + PTR_W'(pop);
    tail_d    = tail_q + PTR_W'(push);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    retired_d = retired_q + 32'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      retired_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      retired_q <= retired_d;
    end
  end

  // Entry storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= data_mem_addr[31:2];
      data_q[tail_q] <= data_mem_wr_data;
    end
`ifdef DMEM_WB_COALESCE_EN
    if (coal) begin
      data_q[coal_idx] <= data_mem_wr_data;
    end
`endif
  end

  assign data_mem_stall   = wr_req & full & ~coal;
  assign data_mem_rd_data = !data_mem_rd_ena ? 32'h0 : (rd_hit ? rd_word : bk_rd_data);
  assign bk_wr_valid      = ~empty;
  assign bk_wr_addr       = {addr_q[head_q], 2'b00};
  assign bk_wr_data       = data_q[head_q];
  assign bk_rd_addr       = {data_mem_addr[31:2], 2'b00};
  assign buffer_count     = count_q;
  assign writes_retired   = retired_q;

endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
Memory-side responder for the pipelined core's data-memory port. It accepts the core's word stores into a DEPTH-entry posted-write FIFO and drains that FIFO to a backing store over a valid/ready write channel. Loads are served combinationally: the youngest matching buffered write is forwarded, otherwise the backing store's combinational read port is used. It sits between the core's memory stage and the data RAM.

Parameters:
DEPTH, 4, number of buffered writes; power of 2, >= 2
CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-low: state cleared at posedge when rst==0
ena  in  1  gates acceptance of new core writes; drain and reads unaffected
data_mem_addr  in  32  core byte address; bits [1:0] ignored (word access only)
data_mem_wr_data  in  32  core store data
data_mem_wr_ena  in  1  core store request
data_mem_rd_ena  in  1  core load request
data_mem_rd_data  out  32  load result to core
data_mem_stall  out  1  store not accepted this cycle; core holds request
bk_wr_valid  out  1  head entry offered to backing store
bk_wr_ready  in  1  backing store accepts head entry
bk_wr_addr  out  32  head word address, {addr[31:2],2'b00}
bk_wr_data  out  32  head data
bk_rd_addr  out  32  passthrough of data_mem_addr, bits [1:0] forced 0
bk_rd_data  in  32  combinational read data from backing store
buffer_count  out  CNT_W  current occupancy, 0..DEPTH
writes_retired  out  32  count of completed backing-store writes

Behaviour:
- Storage: DEPTH entries of {word addr[31:2], data[31:0]}, head/tail pointers, registered count.
- Reset (rst==0 at posedge): pointers, count, writes_retired <= 0. Pending entries discarded even mid-handshake; bk_wr_valid low from the next cycle. Outputs after reset: bk_wr_valid=0, buffer_count=0, writes_retired=0, data_mem_stall=0 unless wr_ena and full (impossible after reset). data_mem_rd_data follows the read rule.
- Push: push = data_mem_wr_ena & ena & (count!=DEPTH). Entry written at tail, tail advances.
- Stall: data_mem_stall = data_mem_wr_ena & ena & (count==DEPTH). It uses the registered full flag only. There is no combinational path from bk_wr_ready, so a same-cycle pop does not clear the stall.
- Drain: bk_wr_valid = (count!=0). pop = bk_wr_valid & bk_wr_ready. bk_wr_addr/bk_wr_data come from the head entry and stay stable while valid & !ready. On pop, head advances and writes_retired increments; writes_retired wraps at 2^32.
- Push and pop in the same cycle: both pointers advance and count is unchanged. When count==0, a push never pops in the same cycle (valid is low until the next cycle). Pointer wrap is modulo DEPTH.
- Read (combinational): if rd_ena==0, rd_data=0. If rd_ena==1, compare addr[31:2] against all valid entries. On a match, return the data of the youngest matching entry (nearest tail). On no match, return bk_rd_data. The read sees buffer contents before the clock edge, so a same-cycle store is not visible. The head entry remains forwardable while it is being popped.
- Write ordering to the backing store is strict FIFO. Without the optional feature, duplicate addresses occupy separate entries.
- Latency: store posted in 1 cycle; earliest backing write offered the cycle after the push; load has 0-cycle latency.

Optional Feature:
Macro DMEM_WB_COALESCE_EN.
- Defined: a store whose word address matches a valid non-head entry overwrites the youngest such entry in place; no push, count unchanged. Such a store is accepted and not stalled even when full. A match only on the head entry is treated as a normal push/stall, so head data never changes under the valid handshake.
- Undefined: no coalescing, behaviour as above.

Test Plan:
1. Hold rst=0 for 2 cycles with wr_ena=1 -> buffer_count=0, bk_wr_valid=0, writes_retired=0, data_mem_stall=0.
2. bk_wr_ready=0; store 0x100<=0xDEADBEEF; next cycle load 0x102 with bk_rd_data=0 -> rd_data=0xDEADBEEF, bk_wr_valid=1, bk_wr_addr=0x100 held stable over 3 cycles.
3. ready=0; stores 0x40<=1, 0x40<=2 (coalesce off) -> count=2, load 0x40 returns 2; then ready=1 -> backing sees data 1 then 2, writes_retired=2.
4. DEPTH=4, ready=0, five consecutive stores -> stall=1 on 5th, count=4. Pulse ready=1 for one cycle -> stall still 1 that cycle, 5th store accepted next edge, count=4.
5. count=2, ready=1, simultaneous store -> count stays 2; tail wraps correctly after 8 such cycles and drain order is preserved.
6. DMEM_WB_COALESCE_EN defined, ready=0: stores 0x10<=A, 0x20<=B, 0x20<=C -> count=2, load 0x20 returns C. Then fill to 4 and store 0x20<=D while full -> no stall, count=4.
